// File: rtl/freq_gate_controller_if.sv
// Counter link, run/signal inputs and result bus of the frequency-counter gate sequencer.
// master: the sequencer; slave: the counter/display environment.
interface freq_gate_controller_if #(
  parameter int unsigned DIGITS_NUM = 6
);
  localparam int unsigned DW = 4 * DIGITS_NUM;

  logic          run_in;
  logic          signal_in;
  logic [DW-1:0] cnt_digits_in;
  logic          cnt_carry_in;
  logic          cnt_enable_out;
  logic          cnt_reset_out;
  logic [DW-1:0] result_out;
  logic          overflow_out;
  logic          result_valid_out;
  logic          gate_active_out;

  modport master (
    input  run_in, signal_in, cnt_digits_in, cnt_carry_in,
    output cnt_enable_out, cnt_reset_out, result_out, overflow_out,
           result_valid_out, gate_active_out
  );

  modport slave (
    output run_in, signal_in, cnt_digits_in, cnt_carry_in,
    input  cnt_enable_out, cnt_reset_out, result_out, overflow_out,
           result_valid_out, gate_active_out
  );
endinterface

// File: rtl/freq_gate_controller.sv
// Frequency-counter measurement sequencer: synchronises signal_in, gates its rising
// edges into the BCD counter for GATE_CYCLES clocks, then latches digits and overflow.
module freq_gate_controller #(
  parameter int unsigned GATE_CYCLES = 10_000_000,
  parameter int unsigned DIGITS_NUM  = 6,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  freq_gate_controller_if.master bus
);
  localparam int unsigned DW = 4 * DIGITS_NUM;
  localparam int unsigned TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] TLOAD = TW'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_GATE, S_LATCH} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   sticky_q, sticky_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [DW-1:0]          result_q, result_d;
  logic                   overflow_q, overflow_d;
  logic                   valid_q, valid_d;

  logic rise_c;
  logic gate_c;
  logic cnt_en_c;

  assign rise_c   = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign gate_c   = (state_q == S_GATE);
  assign cnt_en_c = rise_c & gate_c;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      prev_q     <= 1'b0;
      sticky_q   <= 1'b0;
      timer_q    <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      sticky_q   <= sticky_d;
      timer_q    <= timer_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  // Sequencer: a dropped run_in aborts CLEAR/GATE without touching the held result.
  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[SYNC_STAGES-2:0], bus.signal_in};
    prev_d     = sync_q[SYNC_STAGES-1];
    sticky_d   = sticky_q;
    timer_d    = timer_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.run_in) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        sticky_d = 1'b0;
        timer_d  = TLOAD;
        state_d  = bus.run_in ? S_GATE : S_IDLE;
      end
      S_GATE: begin
        if (cnt_en_c && bus.cnt_carry_in) sticky_d = 1'b1;
        if (!bus.run_in) begin
          state_d = S_IDLE;
        end else if (timer_q == '0) begin
          state_d = S_LATCH;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_LATCH: begin
        result_d   = bus.cnt_digits_in;
        overflow_d = sticky_q;
        valid_d    = 1'b1;
        state_d    = bus.run_in ? S_CLEAR : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cnt_enable_out   = cnt_en_c;
  assign bus.cnt_reset_out    = (state_q == S_CLEAR);
  assign bus.gate_active_out  = gate_c;
  assign bus.result_out       = result_q;
  assign bus.overflow_out     = overflow_q;
  assign bus.result_valid_out = valid_q;
endmodule

// File: tb/tb_freq_gate_controller.sv
// Directed bench for freq_gate_controller: three instances (100/6, 400/2, 1/1 gate/digits)
// each attached to a behavioural BCD counter and a periodic/manual signal source.
module tb_freq_gate_controller;
  logic clk_in = 1'b0;
  logic reset_in;
  int   tests = 0;
  int   fails = 0;

  always #5 clk_in = ~clk_in;

  freq_gate_controller_if #(.DIGITS_NUM(6)) ifa ();
  freq_gate_controller_if #(.DIGITS_NUM(2)) ifb ();
  freq_gate_controller_if #(.DIGITS_NUM(1)) ifc ();

  freq_gate_controller #(.GATE_CYCLES(100), .DIGITS_NUM(6), .SYNC_STAGES(2)) dut_a (
    .clk_in(clk_in), .reset_in(reset_in), .bus(ifa.master));
  freq_gate_controller #(.GATE_CYCLES(400), .DIGITS_NUM(2), .SYNC_STAGES(2)) dut_b (
    .clk_in(clk_in), .reset_in(reset_in), .bus(ifb.master));
  freq_gate_controller #(.GATE_CYCLES(1), .DIGITS_NUM(1), .SYNC_STAGES(2)) dut_c (
    .clk_in(clk_in), .reset_in(reset_in), .bus(ifc.master));

  // Behavioural decimal counters standing in for counter_bcd_Ndigits
  int cnt_a = 0, cnt_b = 0, cnt_c = 0;

  function automatic logic [23:0] to_bcd(input int v);
    logic [23:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < 6; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  always @(posedge clk_in) begin
    if (ifa.cnt_reset_out) cnt_a <= 0;
    else if (ifa.cnt_enable_out) cnt_a <= (cnt_a + 1) % 1000000;
    if (ifb.cnt_reset_out) cnt_b <= 0;
    else if (ifb.cnt_enable_out) cnt_b <= (cnt_b + 1) % 100;
    if (ifc.cnt_reset_out) cnt_c <= 0;
    else if (ifc.cnt_enable_out) cnt_c <= (cnt_c + 1) % 10;
  end

  assign ifa.cnt_digits_in = to_bcd(cnt_a);
  assign ifb.cnt_digits_in = 8'(to_bcd(cnt_b));
  assign ifc.cnt_digits_in = 4'(to_bcd(cnt_c));
  assign ifa.cnt_carry_in  = (cnt_a == 999999) & ifa.cnt_enable_out;
  assign ifb.cnt_carry_in  = (cnt_b == 99) & ifb.cnt_enable_out;
  assign ifc.cnt_carry_in  = (cnt_c == 9) & ifc.cnt_enable_out;

  // Signal sources: periodic square wave when per_x != 0, else the manual level
  int   per_a = 0, per_b = 0, per_c = 0;
  int   ph_a = 0, ph_b = 0, ph_c = 0;
  logic gen_a = 1'b0, gen_b = 1'b0, gen_c = 1'b0;
  logic man_a = 1'b0, man_b = 1'b0, man_c = 1'b0;

  always @(posedge clk_in) begin
    #1;
    if (per_a != 0) begin ph_a = (ph_a + 1) % per_a; gen_a = (ph_a < per_a / 2); end
    if (per_b != 0) begin ph_b = (ph_b + 1) % per_b; gen_b = (ph_b < per_b / 2); end
    if (per_c != 0) begin ph_c = (ph_c + 1) % per_c; gen_c = (ph_c < per_c / 2); end
  end

  assign ifa.signal_in = (per_a != 0) ? gen_a : man_a;
  assign ifb.signal_in = (per_b != 0) ? gen_b : man_b;
  assign ifc.signal_in = (per_c != 0) ? gen_c : man_c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic vld(input int which);
    case (which)
      0:       return ifa.result_valid_out;
      1:       return ifb.result_valid_out;
      default: return ifc.result_valid_out;
    endcase
  endfunction

  // Waits (sampling on negedges) for the next valid strobe; cyc = negedges waited
  task automatic wait_valid(input int which, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk_in);
      cyc++;
    end while (!vld(which) && cyc < 1000);
    check("valid_seen", 32'(vld(which)), 32'd1);
  endtask

  int cyc;
  int nval;

  initial begin
    reset_in    = 1'b0;
    ifa.run_in  = 1'b0;
    ifb.run_in  = 1'b0;
    ifc.run_in  = 1'b0;
    repeat (2) @(negedge clk_in);
    check("rst_result_a", 32'(ifa.result_out), 32'h0);
    check("rst_ovf_a", 32'(ifa.overflow_out), 32'h0);
    check("rst_valid_a", 32'(ifa.result_valid_out), 32'h0);
    check("rst_gate_a", 32'(ifa.gate_active_out), 32'h0);
    check("rst_cntrst_a", 32'(ifa.cnt_reset_out), 32'h0);
    check("rst_result_b", 32'(ifb.result_out), 32'h0);
    reset_in = 1'b1;
    @(negedge clk_in);
    check("idle_cntrst_a", 32'(ifa.cnt_reset_out), 32'h0);
    check("idle_gate_a", 32'(ifa.gate_active_out), 32'h0);

    // One-cycle gate: CLEAR, GATE, LATCH repeat every 3 cycles
    ifc.run_in = 1'b1;
    wait_valid(2, cyc);
    @(negedge clk_in);
    check("c_gate_on", 32'(ifc.gate_active_out), 32'h1);
    @(negedge clk_in);
    check("c_gate_off", 32'(ifc.gate_active_out), 32'h0);
    check("c_valid_low", 32'(ifc.result_valid_out), 32'h0);
    @(negedge clk_in);
    check("c_valid_period3", 32'(ifc.result_valid_out), 32'h1);
    check("c_result", 32'(ifc.result_out), 32'h0);
    ifc.run_in = 1'b0;

    // 2-digit counter: 200 edges wrap to 00 with overflow, then 50 edges
    per_b = 2;
    ifb.run_in = 1'b1;
    wait_valid(1, cyc);
    wait_valid(1, cyc);
    check("b_period", 32'(cyc), 32'd402);
    check("b_wrap_result", 32'(ifb.result_out), 32'h00);
    check("b_wrap_ovf", 32'(ifb.overflow_out), 32'h1);
    per_b = 8;
    wait_valid(1, cyc);
    wait_valid(1, cyc);
    check("b_p8_result", 32'(ifb.result_out), 32'h50);
    check("b_p8_ovf", 32'(ifb.overflow_out), 32'h0);
    ifb.run_in = 1'b0;

    // Main: period-4 input over a 100-cycle gate
    per_a = 4;
    ifa.run_in = 1'b1;
    wait_valid(0, cyc);
    wait_valid(0, cyc);
    check("a_period", 32'(cyc), 32'd102);
    check("a_result", 32'(ifa.result_out), 32'h000025);
    check("a_ovf", 32'(ifa.overflow_out), 32'h0);
    check("a_clear_with_valid", 32'(ifa.cnt_reset_out), 32'h1);
    check("a_no_en_in_clear", 32'(ifa.cnt_enable_out), 32'h0);
    wait_valid(0, cyc);
    check("a_period2", 32'(cyc), 32'd102);
    @(negedge clk_in);
    check("a_valid_one_cycle", 32'(ifa.result_valid_out), 32'h0);
    check("a_gate_after_clear", 32'(ifa.gate_active_out), 32'h1);
    ifa.run_in = 1'b0;
    per_a = 0;
    man_a = 1'b0;
    repeat (5) @(negedge clk_in);
    check("a_idle_gate", 32'(ifa.gate_active_out), 32'h0);

    // Isolated pulse inside the gate
    ifa.run_in = 1'b1;
    @(negedge clk_in);
    check("p_clear", 32'(ifa.cnt_reset_out), 32'h1);
    @(negedge clk_in);
    check("p_gate", 32'(ifa.gate_active_out), 32'h1);
    man_a = 1'b1;
    @(negedge clk_in);
    check("p_en_lat1", 32'(ifa.cnt_enable_out), 32'h0);
    @(negedge clk_in);
    check("p_en_lat2", 32'(ifa.cnt_enable_out), 32'h1);
    @(negedge clk_in);
    check("p_en_single", 32'(ifa.cnt_enable_out), 32'h0);
    repeat (2) @(negedge clk_in);
    man_a = 1'b0;
    wait_valid(0, cyc);
    check("p_result", 32'(ifa.result_out), 32'h000001);
    ifa.run_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // Rising edge landing in CLEAR, then held high through the gate: nothing counted
    man_a = 1'b1;
    @(negedge clk_in);
    ifa.run_in = 1'b1;
    @(negedge clk_in);
    check("cl_clear", 32'(ifa.cnt_reset_out), 32'h1);
    check("cl_no_en", 32'(ifa.cnt_enable_out), 32'h0);
    wait_valid(0, cyc);
    check("hi_result", 32'(ifa.result_out), 32'h000000);
    check("hi_ovf", 32'(ifa.overflow_out), 32'h0);
    ifa.run_in = 1'b0;
    man_a = 1'b0;

    // Abort at gate cycle 50: no strobe, result held, restart through CLEAR
    per_a = 4;
    @(negedge clk_in);
    ifa.run_in = 1'b1;
    wait_valid(0, cyc);
    wait_valid(0, cyc);
    check("ab_pre_result", 32'(ifa.result_out), 32'h000025);
    @(negedge clk_in);
    repeat (49) @(negedge clk_in);
    ifa.run_in = 1'b0;
    @(negedge clk_in);
    check("ab_idle", 32'(ifa.gate_active_out), 32'h0);
    nval = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk_in);
      if (ifa.result_valid_out) nval++;
    end
    check("ab_no_valid", 32'(nval), 32'd0);
    check("ab_held", 32'(ifa.result_out), 32'h000025);
    ifa.run_in = 1'b1;
    @(negedge clk_in);
    check("ab_restart_clear", 32'(ifa.cnt_reset_out), 32'h1);
    @(negedge clk_in);
    check("ab_restart_gate", 32'(ifa.gate_active_out), 32'h1);
    wait_valid(0, cyc);
    check("ab_restart_result", 32'(ifa.result_out), 32'h000025);

    // Asynchronous reset mid-gate, then release between edges with run_in high
    repeat (20) @(negedge clk_in);
    @(posedge clk_in);
    #3 reset_in = 1'b0;
    #1;
    check("ar_result", 32'(ifa.result_out), 32'h0);
    check("ar_gate", 32'(ifa.gate_active_out), 32'h0);
    check("ar_valid", 32'(ifa.result_valid_out), 32'h0);
    check("ar_cntrst", 32'(ifa.cnt_reset_out), 32'h0);
    check("ar_en", 32'(ifa.cnt_enable_out), 32'h0);
    @(negedge clk_in);
    #2 reset_in = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk_in);
      #1;
      cyc++;
    end while (!ifa.result_valid_out && cyc < 1000);
    check("ar_first_valid_edges", 32'(cyc), 32'd103);
    check("ar_result_after", 32'(ifa.result_out), 32'h000025);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
